// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Operand/result handshake bundle for the sequential execute-stage ALU.
//   in_valid / in_ready   : operation offer from the issuing stage
//   src1, src2, opcode    : signed operands and operation select
//   out_valid / out_ready : result offer to the consuming stage
//   data_out, cond_flag   : registered result and branch condition
//   busy                  : an iterative multiply/divide is in progress
// The master modport is the issuing/consuming side, the slave is the ALU.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [OP_WIDTH-1:0]   opcode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  cond_flag;
    logic                  busy;

    modport master (
        output in_valid, src1, src2, opcode, out_ready,
        input  in_ready, out_valid, data_out, cond_flag, busy
    );

    modport slave (
        input  in_valid, src1, src2, opcode, out_ready,
        output in_ready, out_valid, data_out, cond_flag, busy
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered execute-stage ALU. Single-cycle ops (logic, add/sub, compares,
// zero tests, MVHI) complete at the accept edge. MUL/MULH/DIV/REM run one
// bit step per cycle on operand magnitudes and always take DATA_WIDTH+1
// edges from accept to out_valid, independent of operand values.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : alu_seq_if slave (handshakes, operands, result, busy)
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(5'd0);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(5'd1);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(5'd2);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(5'd3);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(5'd4);
    localparam logic [OP_WIDTH-1:0] OP_NAND  = OP_WIDTH'(5'd5);
    localparam logic [OP_WIDTH-1:0] OP_NOR   = OP_WIDTH'(5'd6);
    localparam logic [OP_WIDTH-1:0] OP_XNOR  = OP_WIDTH'(5'd7);
    localparam logic [OP_WIDTH-1:0] OP_F     = OP_WIDTH'(5'd8);
    localparam logic [OP_WIDTH-1:0] OP_EQ    = OP_WIDTH'(5'd9);
    localparam logic [OP_WIDTH-1:0] OP_LT    = OP_WIDTH'(5'd10);
    localparam logic [OP_WIDTH-1:0] OP_LTE   = OP_WIDTH'(5'd11);
    localparam logic [OP_WIDTH-1:0] OP_T     = OP_WIDTH'(5'd12);
    localparam logic [OP_WIDTH-1:0] OP_NE    = OP_WIDTH'(5'd13);
    localparam logic [OP_WIDTH-1:0] OP_GTE   = OP_WIDTH'(5'd14);
    localparam logic [OP_WIDTH-1:0] OP_GT    = OP_WIDTH'(5'd15);
    localparam logic [OP_WIDTH-1:0] OP_MVHI  = OP_WIDTH'(5'd16);
    localparam logic [OP_WIDTH-1:0] OP_BLTZ  = OP_WIDTH'(5'd17);
    localparam logic [OP_WIDTH-1:0] OP_BLTEZ = OP_WIDTH'(5'd18);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(5'd19);
    localparam logic [OP_WIDTH-1:0] OP_MULH  = OP_WIDTH'(5'd20);
    localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(5'd21);
    localparam logic [OP_WIDTH-1:0] OP_REM   = OP_WIDTH'(5'd22);

    localparam logic [DW-1:0] ZERO_DW  = {DW{1'b0}};
    localparam logic [DW-1:0] ONES_DW  = {DW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    // Absolute value as an unsigned DW-bit number; most-negative maps to 2^(DW-1).
    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] x);
        magnitude = x[DW-1] ? -x : x;
    endfunction

    // Result {cond_flag, data} of every single-cycle opcode.
    function automatic logic [DW:0] alu_single(input logic [OP_WIDTH-1:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          f;
        logic          cmp;
        r   = ZERO_DW;
        f   = 1'b0;
        cmp = 1'b0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_MVHI:  r = {b[DW/2-1:0], {(DW/2){1'b0}}};
            OP_F:     begin cmp = 1'b0; f = 1'b1; end
            OP_T:     begin cmp = 1'b1; f = 1'b1; end
            OP_EQ:    begin cmp = (a == b); f = 1'b1; end
            OP_NE:    begin cmp = (a != b); f = 1'b1; end
            OP_LT:    begin cmp = ($signed(a) <  $signed(b)); f = 1'b1; end
            OP_LTE:   begin cmp = ($signed(a) <= $signed(b)); f = 1'b1; end
            OP_GTE:   begin cmp = ($signed(a) >= $signed(b)); f = 1'b1; end
            OP_GT:    begin cmp = ($signed(a) >  $signed(b)); f = 1'b1; end
            OP_BLTZ:  begin cmp = a[DW-1]; f = 1'b1; end
            OP_BLTEZ: begin cmp = a[DW-1] | (a == ZERO_DW); f = 1'b1; end
            default:  r = ZERO_DW;
        endcase
        // f marks the 1/0-result group; its flag mirrors result bit 0.
        if (f) begin
            alu_single = {cmp, {(DW-1){1'b0}}, cmp};
        end else begin
            alu_single = {1'b0, r};
        end
    endfunction

    state_e            state_r;
    state_e            state_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic [2*DW-1:0]   acc_r;
    logic [2*DW-1:0]   acc_nxt_s;
    logic [2*DW-1:0]   prod_s;
    logic [DW-1:0]     opnd_r;
    logic [DW-1:0]     src1_r;
    logic [OP_WIDTH-1:0] op_r;
    logic              sign_a_r;
    logic              neg_r;
    logic              div0_r;
    logic              out_valid_r;
    logic [DW-1:0]     data_out_r;
    logic              cond_flag_r;
    logic              busy_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              in_iter_s;
    logic              in_mul_s;
    logic              run_mul_s;
    logic              done_s;
    logic [DW:0]       single_s;
    logic [DW:0]       mul_sum_s;
    logic [2*DW-1:0]   div_shl_s;
    logic [DW-1:0]     div_hi_s;
    logic [DW-1:0]     quot_s;
    logic [DW-1:0]     rem_s;
    logic [DW-1:0]     fin_data_s;
    logic [DW-1:0]     mag_a_s;
    logic [DW-1:0]     mag_b_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.data_out  = data_out_r;
    assign bus.cond_flag = cond_flag_r;
    assign bus.busy      = busy_r;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && in_iter_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake decode and incoming-op classification.
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
        accept_s   = in_ready_s && bus.in_valid;
        in_mul_s   = (bus.opcode == OP_MUL) || (bus.opcode == OP_MULH);
        in_iter_s  = in_mul_s || (bus.opcode == OP_DIV) || (bus.opcode == OP_REM);
        done_s     = (state_r == ST_BUSY) && (cnt_r == CNT_ONE);
        run_mul_s  = (op_r == OP_MUL) || (op_r == OP_MULH);
        single_s   = alu_single(bus.opcode, bus.src1, bus.src2);
        mag_a_s    = magnitude(bus.src1);
        mag_b_s    = magnitude(bus.src2);
    end

    // One iteration step. Multiply keeps {partial_hi, multiplier} in acc and
    // shifts right; division keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*DW-1:DW]} +
                    (acc_r[0] ? {1'b0, opnd_r} : {(DW+1){1'b0}});
        div_shl_s = {acc_r[2*DW-2:0], 1'b0};
        div_hi_s  = div_shl_s[2*DW-1:DW];
        if (run_mul_s) begin
            acc_nxt_s = {mul_sum_s, acc_r[DW-1:1]};
        end else if (div_hi_s >= opnd_r) begin
            acc_nxt_s = {div_hi_s - opnd_r, div_shl_s[DW-1:1], 1'b1};
        end else begin
            acc_nxt_s = div_shl_s;
        end
    end

    // Sign fix-up and special cases applied to the final step's value.
    always_comb begin
        prod_s = neg_r ? -acc_nxt_s : acc_nxt_s;
        quot_s = neg_r ? -acc_nxt_s[DW-1:0] : acc_nxt_s[DW-1:0];
        rem_s  = sign_a_r ? -acc_nxt_s[2*DW-1:DW] : acc_nxt_s[2*DW-1:DW];
        case (op_r)
            OP_MUL:  fin_data_s = prod_s[DW-1:0];
            OP_MULH: fin_data_s = prod_s[2*DW-1:DW];
            OP_DIV:  fin_data_s = div0_r ? ONES_DW : quot_s;
            OP_REM:  fin_data_s = div0_r ? src1_r : rem_s;
            default: fin_data_s = ZERO_DW;
        endcase
    end

    // Iterative datapath: operand latch on accept, one step per BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= CNT_ZERO;
            acc_r    <= {(2*DW){1'b0}};
            opnd_r   <= ZERO_DW;
            src1_r   <= ZERO_DW;
            op_r     <= {OP_WIDTH{1'b0}};
            sign_a_r <= 1'b0;
            neg_r    <= 1'b0;
            div0_r   <= 1'b0;
        end else if (accept_s && in_iter_s) begin
            cnt_r    <= CNT_INIT;
            op_r     <= bus.opcode;
            src1_r   <= bus.src1;
            sign_a_r <= bus.src1[DW-1];
            neg_r    <= bus.src1[DW-1] ^ bus.src2[DW-1];
            div0_r   <= (bus.src2 == ZERO_DW);
            if (in_mul_s) begin
                acc_r  <= {ZERO_DW, mag_b_s};
                opnd_r <= mag_a_s;
            end else begin
                acc_r  <= {ZERO_DW, mag_a_s};
                opnd_r <= mag_b_s;
            end
        end else if (state_r == ST_BUSY) begin
            cnt_r <= cnt_r - CNT_ONE;
            acc_r <= acc_nxt_s;
        end else begin
            cnt_r <= cnt_r;
            acc_r <= acc_r;
        end
    end

    // Result register and busy flag; a new load wins over a same-edge consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            data_out_r  <= ZERO_DW;
            cond_flag_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept_s && !in_iter_s) begin
            out_valid_r <= 1'b1;
            data_out_r  <= single_s[DW-1:0];
            cond_flag_r <= single_s[DW];
        end else if (accept_s && in_iter_s) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b1;
        end else if (done_s) begin
            out_valid_r <= 1'b1;
            data_out_r  <= fin_data_s;
            cond_flag_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
endmodule
